// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, pc4, inst}
// with first-word fall-through head, synchronous flush and a refused-push pulse.
module inst_queue #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned INST_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [ADDR_WIDTH-1:0]      in_pc,
   input  logic [ADDR_WIDTH-1:0]      in_pc4,
   input  logic [INST_WIDTH-1:0]      in_inst,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_WIDTH-1:0]      out_pc,
   output logic [ADDR_WIDTH-1:0]      out_pc4,
   output logic [INST_WIDTH-1:0]      out_inst,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       drop
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = 2 * ADDR_WIDTH + INST_WIDTH;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               drop_q, drop_d;
   logic               push_c, pop_c;
   logic [ENTRY_W-1:0] head_c;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = count_q;
   assign drop      = drop_q;

   assign push_c = in_valid && in_ready && !flush;
   assign pop_c  = out_valid && out_ready && !flush;

   // Head presented straight from storage; zeroed while empty so stale data never leaks.
   assign head_c   = empty ? '0 : mem_q[rd_ptr_q];
   assign out_pc   = head_c[ENTRY_W-1 -: ADDR_WIDTH];
   assign out_pc4  = head_c[INST_WIDTH +: ADDR_WIDTH];
   assign out_inst = head_c[INST_WIDTH-1:0];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = in_valid && !in_ready && !flush;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth lets the pointers wrap by natural overflow.
         wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
         rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
         count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // Storage is deliberately unreset; it is only visible through head_c when occupied.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= {in_pc, in_pc4, in_inst};
      end
   end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, width of the PC fields.
REQ-002 SHALL have parameter INST_WIDTH, default 32, width of the instruction word.
REQ-003 SHALL have parameter DEPTH, default 4, number of entries; legal values are powers of two, 2 or greater.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all entries (fetch redirect).
REQ-007 SHALL have port in_valid  input  1  fetch offers an entry this cycle.
REQ-008 SHALL have port in_pc  input  ADDR_WIDTH  PC of the offered instruction.
REQ-009 SHALL have port in_pc4  input  ADDR_WIDTH  PC+4 of the offered instruction.
REQ-010 SHALL have port in_inst  input  INST_WIDTH  offered instruction word.
REQ-011 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-012 SHALL have port out_valid  output  1  head entry is available to decode.
REQ-013 SHALL have port out_ready  input  1  decode consumes the head this cycle.
REQ-014 SHALL have port out_pc  output  ADDR_WIDTH  head PC.
REQ-015 SHALL have port out_pc4  output  ADDR_WIDTH  head PC+4.
REQ-016 SHALL have port out_inst  output  INST_WIDTH  head instruction.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-018 SHALL have port empty  output  1  count == 0.
REQ-019 SHALL have port full  output  1  count == DEPTH.
REQ-020 SHALL have port drop  output  1  one-cycle pulse when an offered entry was refused.

Function
REQ-021 SHALL implement a circular buffer of DEPTH entries {pc, pc4, inst} with read and write pointers that wrap modulo DEPTH.
REQ-022 SHALL drive in_ready = !full combinationally; a push occurs when in_valid && in_ready && !flush.
REQ-023 SHALL perform a pop when out_valid && out_ready && !flush; the read pointer advances by one.
REQ-024 SHALL drive out_valid = !empty, with the head entry presented combinationally from storage (first-word fall-through).
REQ-025 SHALL drive out_pc, out_pc4 and out_inst to 0 while empty.
REQ-026 SHALL make an entry pushed at edge N visible on out_* in the cycle following edge N; there is no same-cycle bypass from in_* to out_*.
REQ-027 SHALL handle a simultaneous push and pop when non-empty and non-full by moving both pointers and leaving count unchanged.
REQ-028 SHALL refuse a push when full, even if a pop occurs in the same cycle, because in_ready depends only on full.
REQ-029 SHALL, on a pop while empty, change no state (out_valid = 0 makes the pop impossible).
REQ-030 SHALL, when flush = 1 at an edge, set both pointers and count to 0 and ignore any push or pop in that cycle.
REQ-031 SHALL register drop = 1 for exactly one cycle after an edge at which in_valid && !in_ready && !flush; otherwise drop = 0.
REQ-032 SHALL preserve entry order: entries leave in exactly the order they were accepted.

Reset
REQ-033 SHALL, while reset = 1, asynchronously force the pointers to 0, count = 0, empty = 1, full = 0, out_valid = 0, drop = 0 and out_* = 0.
REQ-034 SHALL leave the storage array unreset; its contents are never observable while empty.
REQ-035 SHALL discard all entries when reset is asserted mid-operation; the first push after reset release appears as the only entry.

Verification
REQ-036 Directed case SHALL cover basic pass-through: push {pc=0x1000, pc4=0x1004, inst=0x00000013} with out_ready=0 -> next cycle out_valid=1, out_pc=0x1000, count=1; then out_ready=1 -> empty=1 the following cycle.
REQ-037 Directed case SHALL cover fill and drop: push pc=0x0,0x4,0x8,0xC, then offer 0x10 with out_ready=0 -> full=1, in_ready=0, drop=1 for one cycle, count stays 4; pops then return 0x0,0x4,0x8,0xC.
REQ-038 Directed case SHALL cover wrap-around: ten cycles with push and pop both active, starting from count=2 -> count stays 2 and output PCs are strictly in push order across the pointer wrap.
REQ-039 Directed case SHALL cover flush: count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, empty=1, out_pc=0, and the offered entry is lost.
REQ-040 Directed case SHALL cover async reset: count=2, assert reset between clock edges -> out_valid=0 and count=0 immediately without waiting for a clock edge; after release, push 0x2000 -> out_pc=0x2000, count=1.
REQ-041 Directed case SHALL cover pop on empty: out_ready=1 with empty=1 for 3 cycles -> count stays 0 and no pointer change is observable on a subsequent push.
